// File: rtl/chnl_tx_framer.sv
// chnl_tx_framer: record framer in front of chnl_tx (32-bit words).
//
// Each input record goes out as its payload words, then zero pad words, then one
// trailer word. Every framed record is a whole multiple of CHNL_ALIGN words, so
// chnl_tx idle-flushes and aligned transfers always carry complete records.
//
// Trailer layout: [31:24] tag, [23:16] seq, [15] trunc, [14:0] n (payload word count).
// A record is closed by i_last, or forcibly once MAX_WORDS words have been taken
// (trunc=1 if i_last was not set on that word).
//
// Optional feature macro: CHNL_TX_FRAMER_CSUM_EN
//   defined   : tag is the XOR fold of every byte of every payload word of the record
//   undefined : tag is the MAGIC parameter; no checksum logic is built
//
// Ports:
//   clk     in   clock
//   rst     in   asynchronous active-high reset
//   i_val   in   input word valid
//   i_rdy   out  input word accepted when i_val && i_rdy
//   i_data  in   payload word [31:0]
//   i_last  in   final word of the record (sampled only on accept)
//   o_val   out  output word valid (registered)
//   o_rdy   in   downstream ready
//   o_data  out  framed word [31:0] (registered)
//   o_busy  out  record open: payload accepted, trailer not yet issued
module chnl_tx_framer #(
  parameter int unsigned CHNL_ALIGN = 4,
  parameter int unsigned MAX_WORDS  = 1024,
  parameter logic [7:0]  MAGIC      = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_val,
  output logic        i_rdy,
  input  logic [31:0] i_data,
  input  logic        i_last,
  output logic        o_val,
  input  logic        o_rdy,
  output logic [31:0] o_data,
  output logic        o_busy
);

  localparam logic [15:0] CaW   = 16'(CHNL_ALIGN);
  localparam logic [15:0] MaxW  = 16'(MAX_WORDS);

  typedef enum logic [1:0] {
    StPayload = 2'd0,
    StPad     = 2'd1,
    StTrailer = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [14:0] cnt_q, cnt_d;
  logic [15:0] pad_q, pad_d;
  logic [7:0]  seq_q, seq_d;
  logic        trunc_q, trunc_d;
  logic        busy_q, busy_d;
  logic        o_val_q, o_val_d;
  logic [31:0] o_data_q, o_data_d;

  logic        free;
  logic [15:0] n_next;
  logic [15:0] pad_calc;
  logic [7:0]  tag;

`ifdef CHNL_TX_FRAMER_CSUM_EN
  logic [7:0] csum_q, csum_d;
  assign tag = csum_q;
`else
  assign tag = MAGIC;
`endif

  // The output register may take a new word when it is empty or being drained.
  assign free   = !o_val_q || o_rdy;
  assign n_next = {1'b0, cnt_q} + 16'd1;

  // Pad so that payload + trailer is a multiple of CHNL_ALIGN.
  always_comb begin
    pad_calc = (CaW - ((n_next + 16'd1) % CaW)) % CaW;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pad_d    = pad_q;
    seq_d    = seq_q;
    trunc_d  = trunc_q;
    busy_d   = busy_q;
    o_val_d  = o_val_q && !o_rdy;
    o_data_d = o_data_q;
    i_rdy    = 1'b0;
`ifdef CHNL_TX_FRAMER_CSUM_EN
    csum_d   = csum_q;
`endif

    unique case (state_q)
      StPayload: begin
        i_rdy = free;
        if (i_val && free) begin
          o_val_d  = 1'b1;
          o_data_d = i_data;
          cnt_d    = n_next[14:0];
          busy_d   = 1'b1;
`ifdef CHNL_TX_FRAMER_CSUM_EN
          csum_d   = csum_q ^ i_data[31:24] ^ i_data[23:16] ^ i_data[15:8] ^ i_data[7:0];
`endif
          if (i_last || (n_next == MaxW)) begin
            trunc_d = !i_last;
            pad_d   = pad_calc;
            state_d = (pad_calc != 16'd0) ? StPad : StTrailer;
          end
        end
      end

      StPad: begin
        if (free) begin
          o_val_d  = 1'b1;
          o_data_d = 32'h0;
          pad_d    = pad_q - 16'd1;
          if (pad_q == 16'd1) begin
            state_d = StTrailer;
          end
        end
      end

      StTrailer: begin
        if (free) begin
          o_val_d  = 1'b1;
          o_data_d = {tag, seq_q, trunc_q, cnt_q};
          seq_d    = seq_q + 8'd1;
          cnt_d    = 15'd0;
          trunc_d  = 1'b0;
          busy_d   = 1'b0;
          state_d  = StPayload;
`ifdef CHNL_TX_FRAMER_CSUM_EN
          csum_d   = 8'h00;
`endif
        end
      end

      default: begin
        state_d = StPayload;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StPayload;
      cnt_q    <= 15'd0;
      pad_q    <= 16'd0;
      seq_q    <= 8'd0;
      trunc_q  <= 1'b0;
      busy_q   <= 1'b0;
      o_val_q  <= 1'b0;
      o_data_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pad_q    <= pad_d;
      seq_q    <= seq_d;
      trunc_q  <= trunc_d;
      busy_q   <= busy_d;
      o_val_q  <= o_val_d;
      o_data_q <= o_data_d;
    end
  end

`ifdef CHNL_TX_FRAMER_CSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_q <= 8'h00;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

  assign o_val  = o_val_q;
  assign o_data = o_data_q;
  assign o_busy = busy_q;

endmodule

// File: tb/tb_chnl_tx_framer.sv
// Scoreboard bench for chnl_tx_framer with CHNL_ALIGN=4, MAX_WORDS=8.
// The driver feeds words into a record-level reference model that pushes the
// expected framed stream; a negedge monitor pops and compares every transfer.
module tb_chnl_tx_framer;

  localparam int CA = 4;
  localparam int MW = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_val = 1'b0;
  logic        i_rdy;
  logic [31:0] i_data = 32'h0;
  logic        i_last = 1'b0;
  logic        o_val;
  logic        o_rdy = 1'b1;
  logic [31:0] o_data;
  logic        o_busy;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  bit          exp_trl_q[$];
  logic [31:0] trl_log[$];

  int          m_cnt  = 0;
  logic [7:0]  m_seq  = 8'h0;
  logic [7:0]  m_fold = 8'h0;

  bit          rdy_rand = 1'b0;
  bit          hold = 1'b0;
  logic [31:0] hold_data = 32'h0;
  int          flen = 0;

  chnl_tx_framer #(
    .CHNL_ALIGN (CA),
    .MAX_WORDS  (MW),
    .MAGIC      (8'hA5)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .i_val  (i_val),
    .i_rdy  (i_rdy),
    .i_data (i_data),
    .i_last (i_last),
    .o_val  (o_val),
    .o_rdy  (o_rdy),
    .o_data (o_data),
    .o_busy (o_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    o_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h req=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] fold(input logic [31:0] d);
    return d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
  endfunction

  // Reference: a record closes on i_last or at MW words; pad makes n+1 a multiple of CA.
  function automatic void model_accept(input logic [31:0] d, input logic l);
    int         pad;
    logic [7:0] tag;
    exp_q.push_back(d);
    exp_trl_q.push_back(1'b0);
    m_cnt++;
    m_fold ^= fold(d);
    if (l || m_cnt == MW) begin
      pad = (CA - ((m_cnt + 1) % CA)) % CA;
      for (int i = 0; i < pad; i++) begin
        exp_q.push_back(32'h0);
        exp_trl_q.push_back(1'b0);
      end
`ifdef CHNL_TX_FRAMER_CSUM_EN
      tag = m_fold;
`else
      tag = 8'hA5;
`endif
      exp_q.push_back({tag, m_seq, ~l, 15'(m_cnt)});
      exp_trl_q.push_back(1'b1);
      m_seq  = m_seq + 8'd1;
      m_cnt  = 0;
      m_fold = 8'h0;
    end
  endfunction

  // Monitor: transfers complete at the next posedge when o_val && o_rdy here.
  always @(negedge clk) begin
    logic [31:0] e;
    bit          t;
    if (rst) begin
      hold = 1'b0;
      flen = 0;
    end else begin
      if (hold) begin
        chk("hold_val", 32'(o_val), 32'd1);
        chk("hold_data", o_data, hold_data);
      end
      hold      = o_val && !o_rdy;
      hold_data = o_data;
      if (o_val && o_rdy) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word act=%h req=none t=%0t", o_data, $time);
        end else begin
          e = exp_q.pop_front();
          t = exp_trl_q.pop_front();
          chk("data", o_data, e);
          chk("busy", 32'(o_busy), 32'(!t));
          flen++;
          if (t) begin
            chk("frame_len_mod", 32'(flen % CA), 32'd0);
            flen = 0;
            trl_log.push_back(o_data);
          end
        end
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic l);
    int n = 0;
    i_val  = 1'b1;
    i_data = d;
    i_last = l;
    forever begin
      @(negedge clk);
      if (i_rdy) break;
      n++;
      if (n > 2000) begin
        total++;
        bad++;
        $display("FAIL accept_timeout act=stalled req=accept t=%0t", $time);
        break;
      end
    end
    @(posedge clk);
    #1;
    if (n <= 2000) model_accept(d, l);
    i_val  = 1'b0;
    i_last = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20000) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout act=%0d left req=0", exp_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    exp_trl_q.delete();
    trl_log.delete();
    m_cnt  = 0;
    m_seq  = 8'h0;
    m_fold = 8'h0;
    rst    = 1'b0;
  endtask

  initial begin
    int len;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_o_val", 32'(o_val), 32'd0);
    chk("rst_o_data", o_data, 32'h0);
    chk("rst_o_busy", 32'(o_busy), 32'd0);
    chk("rst_i_rdy", 32'(i_rdy), 32'd1);
    @(posedge clk);
    #1;

    // 1: short record with no pad
    send(32'd1, 1'b0);
    send(32'd2, 1'b0);
    send(32'd3, 1'b1);
    drain();
`ifndef CHNL_TX_FRAMER_CSUM_EN
    chk("t1_trl", (trl_log.size() > 0) ? trl_log[0] : 32'hDEAD_BEEF, 32'hA500_0003);
`endif

    // 2: one-word record then a full 4-word record
    do_reset();
    send(32'd7, 1'b1);
    for (int i = 0; i < 4; i++) send(32'h100 + 32'(i), i == 3);
    drain();
`ifndef CHNL_TX_FRAMER_CSUM_EN
    chk("t2_trl0", (trl_log.size() > 0) ? trl_log[0] : 32'hDEAD_BEEF, 32'hA500_0001);
    chk("t2_trl1", (trl_log.size() > 1) ? trl_log[1] : 32'hDEAD_BEEF, 32'hA501_0004);
`endif

    // 3: over-long record is truncated at MW and the rest forms a new record
    do_reset();
    for (int i = 0; i < 10; i++) send(32'h200 + 32'(i), i == 9);
    drain();
`ifndef CHNL_TX_FRAMER_CSUM_EN
    chk("t3_trl0", (trl_log.size() > 0) ? trl_log[0] : 32'hDEAD_BEEF, 32'hA500_8008);
    chk("t3_trl1", (trl_log.size() > 1) ? trl_log[1] : 32'hDEAD_BEEF, 32'hA501_0002);
`endif

    // 4: random records under random backpressure and input gaps
    rdy_rand = 1'b1;
    for (int r = 0; r < 200; r++) begin
      len = $urandom_range(1, 11);
      for (int i = 0; i < len; i++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
        send($urandom, i == len - 1);
      end
    end
    drain();
    rdy_rand = 1'b0;
    repeat (2) @(posedge clk);
    #1;

`ifdef CHNL_TX_FRAMER_CSUM_EN
    // 6: checksum tag
    do_reset();
    send(32'h0102_0304, 1'b0);
    send(32'h1000_0000, 1'b1);
    drain();
    chk("t6_trl", (trl_log.size() > 0) ? trl_log[0] : 32'hDEAD_BEEF, 32'h1400_0002);
`endif

    // 5: sequence wrap over 257 records
    do_reset();
    for (int r = 0; r < 257; r++) send(32'h0, 1'b1);
    drain();
    chk("t5_count", 32'(trl_log.size()), 32'd257);
    chk("t5_seq255", (trl_log.size() > 255) ? {8'h0, trl_log[255][23:0]} : 32'hDEAD_BEEF,
        32'h00FF_0001);
    chk("t5_wrap", (trl_log.size() > 256) ? {8'h0, trl_log[256][23:0]} : 32'hDEAD_BEEF,
        32'h0000_0001);

    // reset in the middle of a record drops it entirely
    send(32'h11, 1'b0);
    send(32'h22, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_o_val", 32'(o_val), 32'd0);
    chk("midrst_o_busy", 32'(o_busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    exp_trl_q.delete();
    trl_log.delete();
    m_cnt  = 0;
    m_seq  = 8'h0;
    m_fold = 8'h0;
    rst    = 1'b0;
    send(32'h0, 1'b1);
    drain();
    chk("midrst_trl", (trl_log.size() > 0) ? {8'h0, trl_log[0][23:0]} : 32'hDEAD_BEEF,
        32'h0000_0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
